// File: rtl/io_mmio_ctrl_pkg.sv
// Shared I/O map for the MMIO sequencer: region tag, register offsets,
// STATUS bit positions and TX FSM encodings.
package io_mmio_ctrl_pkg;

  localparam logic [3:0] IO_REGION = 4'b1000;

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RX_DATA = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTR   = 8'h14;
  localparam logic [7:0] OFF_CNT_RST = 8'h18;

  localparam int ST_TX_IDLE     = 0;
  localparam int ST_RX_NONEMPTY = 1;
  localparam int ST_RX_FULL     = 2;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_mmio_ctrl_rx_fifo.sv
// Receive-byte FIFO: ready/valid push side, pop strobe with head peek.
// DEPTH must be a power of two so the pointers wrap for free.
module io_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  // Ready comes from the registered count, so a pop never frees a slot in the same cycle.
  assign push_ready = !full;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];

  // NOTE: storage is not reset; count alone decides what is valid, and skipping
  // the reset keeps the array mappable to plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO sequencer for the 0x8xxxxxxx region: UART TX handshake, RX FIFO, status
// and counters. Define IO_COUNTERS_EN to build the CYCLE/INSTR counters.
module io_mmio_ctrl
  import io_mmio_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [3:0]  io_we,
  input  logic        io_re,
  input  logic [31:0] io_wdata,
  input  logic        inst_retire,
  output logic [31:0] io_rdata,
  output logic        stall,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  tx_state_e   state;
  tx_state_e   state_next;
  logic        in_region;
  logic [7:0]  off;
  logic        is_store;
  logic        tx_wr;
  logic        tx_load;
  logic        rx_pop;
  logic [7:0]  rx_head;
  logic        rx_full;
  logic        rx_empty;
  logic [31:0] cycle_rd;
  logic [31:0] instr_rd;

  assign in_region = (io_addr[31:28] == IO_REGION);
  assign off       = io_addr[7:0];
  assign is_store  = in_region && (io_we != 4'b0000);
  assign tx_wr     = is_store && (off == OFF_TX_DATA);
  assign rx_pop    = io_re && in_region && (off == OFF_RX_DATA);
  // A stalled store is replayed by the pipeline, so only an unstalled one loads the byte.
  assign tx_load   = tx_wr && !stall;

  io_rx_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  (rx_data),
    .push_valid (rx_valid),
    .push_ready (rx_ready),
    .pop        (rx_pop),
    .head       (rx_head),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE: if (tx_wr) state_next = TX_SEND;
      TX_SEND: if (tx_ready && !tx_wr) state_next = TX_IDLE;
      default: state_next = TX_IDLE;
    endcase
  end

  // NOTE: outputs get a default before the case so no latch is inferred.
  always_comb begin
    tx_valid = 1'b0;
    stall    = 1'b0;
    if (state == TX_SEND) begin
      tx_valid = 1'b1;
      stall    = tx_wr && !tx_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tx_data <= 8'h00;
    else if (tx_load) tx_data <= io_wdata[7:0];
  end

`ifdef IO_COUNTERS_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             cnt_clr;

  assign cnt_clr = is_store && (off == OFF_CNT_RST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (inst_retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign cycle_rd = 32'(cycle_cnt);
  assign instr_rd = 32'(instr_cnt);

  logic unused_ok;
  assign unused_ok = ^{io_wdata[31:8], io_addr[27:8]};
`else
  assign cycle_rd = 32'h0;
  assign instr_rd = 32'h0;

  logic unused_ok;
  assign unused_ok = ^{io_wdata[31:8], io_addr[27:8], inst_retire};
`endif

  always_comb begin
    io_rdata = 32'h0;
    if (in_region) begin
      case (off)
        OFF_STATUS: begin
          io_rdata[ST_TX_IDLE]     = (state == TX_IDLE);
          io_rdata[ST_RX_NONEMPTY] = !rx_empty;
          io_rdata[ST_RX_FULL]     = rx_full;
        end
        OFF_RX_DATA: io_rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
        OFF_CYCLE:   io_rdata = cycle_rd;
        OFF_INSTR:   io_rdata = instr_rd;
        default:     io_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_io_mmio_ctrl;

  localparam int RX_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] io_addr;
  logic [3:0]  io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic        inst_retire;
  logic [31:0] io_rdata;
  logic        stall;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  io_mmio_ctrl #(.RX_DEPTH(RX_DEPTH), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_addr     (io_addr),
    .io_we       (io_we),
    .io_re       (io_re),
    .io_wdata    (io_wdata),
    .inst_retire (inst_retire),
    .io_rdata    (io_rdata),
    .stall       (stall),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: RX bytes in a queue, one pending TX byte, two plain counters.
  bit [7:0]  m_q[$];
  bit        m_busy;
  bit [7:0]  m_byte;
  bit [31:0] m_cyc;
  bit [31:0] m_ins;

  function automatic bit hit(input logic [7:0] o);
    return (io_addr[31:28] == 4'h8) && (io_addr[7:0] == o);
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = 32'h0;
    if (hit(8'h00)) begin
      r[0] = !m_busy;
      r[1] = (m_q.size() > 0);
      r[2] = (m_q.size() == RX_DEPTH);
    end else if (hit(8'h04)) begin
      r = (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
    end
`ifdef IO_COUNTERS_EN
    else if (hit(8'h10)) r = m_cyc;
    else if (hit(8'h14)) r = m_ins;
`endif
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_byte = 8'h00;
      m_cyc  = 32'h0;
      m_ins  = 32'h0;
    end else begin
      bit do_pop;
      bit do_push;
      bit tx_st;
      do_pop  = io_re && hit(8'h04) && (m_q.size() > 0);
      do_push = rx_valid && (m_q.size() < RX_DEPTH);
      tx_st   = (io_we != 4'h0) && hit(8'h08);
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(rx_data);
      if (!m_busy) begin
        if (tx_st) begin
          m_busy = 1'b1;
          m_byte = io_wdata[7:0];
        end
      end else if (tx_ready) begin
        if (tx_st) m_byte = io_wdata[7:0];
        else       m_busy = 1'b0;
      end
`ifdef IO_COUNTERS_EN
      if ((io_we != 4'h0) && hit(8'h18)) begin
        m_cyc = 32'h0;
        m_ins = 32'h0;
      end else begin
        m_cyc = m_cyc + 1;
        if (inst_retire) m_ins = m_ins + 1;
      end
`endif
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rdata",    io_rdata, exp_rdata());
      check("model_stall",    stall,    m_busy && (io_we != 4'h0) && hit(8'h08) && !tx_ready);
      check("model_tx_valid", tx_valid, m_busy);
      check("model_tx_data",  tx_data,  m_byte);
      check("model_rx_ready", rx_ready, m_q.size() < RX_DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] drain [4];
    logic [7:0] offs [7];
    int r;
    drain = '{8'h31, 8'h32, 8'h33, 8'h20};
    offs  = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10, 8'h14, 8'h18};

    rst = 1'b1; io_addr = 32'h0; io_we = 4'h0; io_re = 1'b0; io_wdata = 32'h0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    io_addr = 32'h8000_0000; io_re = 1'b1;
    @(negedge clk);
    check("reset_status",   io_rdata, 32'h1);
    check("reset_rx_ready", rx_ready, 1'b1);
    check("reset_tx_valid", tx_valid, 1'b0);

    // TX: first store, second store stalls until handshake
    tick(); io_re = 1'b0; io_addr = 32'h8000_0008; io_we = 4'hf; io_wdata = 32'h41;
    @(negedge clk);
    check("tx_first_no_stall", stall, 1'b0);
    check("tx_first_not_valid", tx_valid, 1'b0);
    tick(); io_wdata = 32'h42;
    @(negedge clk);
    check("tx_valid_after_store", tx_valid, 1'b1);
    check("tx_data_41", tx_data, 32'h41);
    check("tx_second_stalls", stall, 1'b1);
    tick();
    @(negedge clk);
    check("tx_still_stalled", stall, 1'b1);
    check("tx_data_held", tx_data, 32'h41);
    tick(); tx_ready = 1'b1;
    @(negedge clk);
    check("tx_stall_drops", stall, 1'b0);
    tick(); io_we = 4'h0; tx_ready = 1'b0;
    @(negedge clk);
    check("tx_no_bubble", tx_valid, 1'b1);
    check("tx_data_42", tx_data, 32'h42);
    tick(); tx_ready = 1'b1;
    tick(); tx_ready = 1'b0;
    @(negedge clk);
    check("tx_back_idle", tx_valid, 1'b0);

    // RX fill and drain
    for (int i = 0; i < 4; i++) begin
      tick(); rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
    end
    tick(); rx_valid = 1'b0; io_addr = 32'h8000_0000;
    @(negedge clk);
    check("rx_full_status", io_rdata, 32'h7);
    check("rx_full_ready", rx_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); io_addr = 32'h8000_0004; io_re = 1'b1;
      @(negedge clk);
      check("rx_pop_order", io_rdata, 32'h10 + i);
    end
    tick();
    @(negedge clk);
    check("rx_empty_read", io_rdata, 32'h0);
    tick(); io_re = 1'b0; io_addr = 32'h8000_0000;
    @(negedge clk);
    check("rx_empty_status", io_rdata, 32'h1);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      tick(); rx_valid = 1'b1; rx_data = 8'h30 + 8'(i);
    end
    tick(); io_addr = 32'h8000_0004; io_re = 1'b1; rx_data = 8'h20;
    @(negedge clk);
    check("full_pop_head", io_rdata, 32'h30);
    check("full_push_blocked", rx_ready, 1'b0);
    tick(); io_re = 1'b0; io_addr = 32'h8000_0000;
    @(negedge clk);
    check("push_waits_ready", rx_ready, 1'b1);
    check("push_waits_status", io_rdata, 32'h3);
    tick(); rx_valid = 1'b0;
    @(negedge clk);
    check("refilled_status", io_rdata, 32'h7);
    for (int i = 0; i < 4; i++) begin
      tick(); io_addr = 32'h8000_0004; io_re = 1'b1;
      @(negedge clk);
      check("drain_order", io_rdata, {24'h0, drain[i]});
    end
    tick(); io_re = 1'b0;

    // Counters
`ifdef IO_COUNTERS_EN
    io_addr = 32'h8000_0018; io_we = 4'hf;
    tick(); io_we = 4'h0; io_addr = 32'h8000_0010; inst_retire = 1'b1;
    @(negedge clk);
    check("cycle_after_clear", io_rdata, 32'h0);
    repeat (60) tick();
    inst_retire = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    check("cycle_100", io_rdata, 32'd100);
    io_addr = 32'h8000_0014;
    #1 check("instr_60", io_rdata, 32'd60);
    tick(); io_addr = 32'h8000_0018; io_we = 4'h1;
    tick(); io_we = 4'h0; io_addr = 32'h8000_0010;
    @(negedge clk);
    check("cycle_cleared", io_rdata, 32'h0);
    tick(); io_addr = 32'h8000_0014;
    @(negedge clk);
    check("instr_cleared", io_rdata, 32'h0);
`else
    inst_retire = 1'b1; io_addr = 32'h8000_0010;
    repeat (5) tick();
    @(negedge clk);
    check("cycle_absent", io_rdata, 32'h0);
    tick(); io_addr = 32'h8000_0014;
    @(negedge clk);
    check("instr_absent", io_rdata, 32'h0);
    tick(); inst_retire = 1'b0;
`endif

    // Reset mid-transfer
    tick(); io_addr = 32'h8000_0008; io_we = 4'hf; io_wdata = 32'h55;
    tick(); io_we = 4'h0; rx_valid = 1'b1; rx_data = 8'ha1;
    tick(); rx_data = 8'ha2;
    tick(); rx_valid = 1'b0; io_addr = 32'h8000_0000;
    @(negedge clk);
    check("pre_reset_tx_valid", tx_valid, 1'b1);
    check("pre_reset_status", io_rdata, 32'h2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx_valid", tx_valid, 1'b0);
    check("async_rst_status", io_rdata, 32'h1);
    check("async_rst_rx_ready", rx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_status", io_rdata, 32'h1);
    check("post_rst_tx_valid", tx_valid, 1'b0);

    // Randomized traffic, checked every cycle by the compare process
    repeat (3000) begin
      tick();
      r = $urandom_range(0, 9);
      io_we = 4'h0; io_re = 1'b0;
      io_addr = {4'h8, 20'($urandom), offs[$urandom_range(0, 6)]};
      if (r < 3) begin
        io_re = 1'b1;
        io_addr[7:0] = 8'h04;
      end else if (r < 5) begin
        io_re = 1'b1;
      end else if (r < 8) begin
        io_we = 4'($urandom_range(1, 15));
        if (r == 7) io_addr[7:0] = 8'h08;
      end
      io_wdata    = $urandom;
      rx_valid    = 1'($urandom_range(0, 1));
      rx_data     = 8'($urandom);
      tx_ready    = ($urandom_range(0, 2) == 0);
      inst_retire = 1'($urandom_range(0, 1));
    end
    tick();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_mmio_ctrl.md
Name: io_mmio_ctrl

Overview:
- Sequencer for the memory-mapped I/O region (A[31:28] == 4'b1000) selected by the CPU memory-control decode.
- Owns the UART transmit handshake, buffers received bytes in a small FIFO, and exposes status and counter registers.
- Asserts a stall to the pipeline when a transmit store cannot complete in the current cycle.

Parameters:
- RX_DEPTH, 4: RX FIFO entries; power of two, minimum 2.
- CNT_W, 32: width of the cycle and instruction counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- io_addr  in  32  byte address of the current load/store
- io_we  in  4  byte write mask for the I/O region (nonzero means store)
- io_re  in  1  load targets the I/O region
- io_wdata  in  32  store data
- inst_retire  in  1  one instruction retired this cycle
- io_rdata  out  32  load data, combinational from io_addr and state
- stall  out  1  hold the pipeline this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts the byte
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller accepts rx_data

Behaviour:
- Register map, decoded on io_addr[7:0]:
  - 0x00 STATUS (read): bit0 = tx_idle, bit1 = rx_nonempty, bit2 = rx_full; all other bits 0.
  - 0x04 RX_DATA (read): {24'b0, FIFO head}. Pops one entry on io_re at the clock edge. Reading an empty FIFO returns 0 and does not pop.
  - 0x08 TX_DATA (write): io_wdata[7:0]. Any nonzero io_we counts as the write.
  - 0x10 CYCLE (read).
  - 0x14 INSTR (read).
  - 0x18 CNT_RST (write): any store clears both counters.
  - Unmapped offsets read 0; writes to them are ignored.
- TX FSM, two states:
  - TX_IDLE: tx_valid = 0. A TX_DATA store captures the byte into tx_data and moves to TX_SEND at the next edge. No stall.
  - TX_SEND: tx_valid = 1. On tx_valid && tx_ready, return to TX_IDLE.
  - A TX_DATA store arriving in TX_SEND raises stall (combinational) until the handshake completes. In the cycle tx_ready is high, stall drops, the new byte is captured, and the FSM stays in TX_SEND. There is no bubble and no byte is lost.
  - tx_data is held stable while tx_valid = 1.
- RX FIFO:
  - rx_ready = !full.
  - Push on rx_valid && rx_ready.
  - Simultaneous push and pop is legal at any occupancy, including when full: if the pop makes room, rx_ready stays low that cycle and the push waits one cycle.
  - Pointers wrap modulo RX_DEPTH. Occupancy counter is clog2(RX_DEPTH)+1 bits wide.
- Counters:
  - CYCLE increments every clock.
  - INSTR increments when inst_retire = 1.
  - Both wrap modulo 2^CNT_W.
  - CNT_RST has priority over increment; the counter reads 0 on the next cycle.
  - io_rdata zero-extends when CNT_W < 32 and truncates when CNT_W > 32.
- Reset values: tx_valid 0, tx_data 0, FSM in TX_IDLE, FIFO empty (rx_ready 1), counters 0, stall 0. io_rdata follows decode, so STATUS reads 0x1.
- Reset mid-transfer: a pending TX byte is dropped and buffered RX bytes are discarded.
- Latency:
  - Load data is available in the same cycle.
  - A store takes effect at the next edge.
  - tx_valid rises one cycle after the store.

Optional Feature:
- IO_COUNTERS_EN
  - Defined: CYCLE and INSTR are implemented as above and CNT_RST is functional.
  - Undefined: no counter flops are built, offsets 0x10 and 0x14 read 0, CNT_RST is ignored, and inst_retire is unused.

Decomposition:
- Shared header IoMap.vh holds:
  - the I/O region tag 4'b1000
  - register offsets STATUS, RX_DATA, TX_DATA, CYCLE, INSTR, CNT_RST
  - STATUS bit indices
  - TX FSM state encodings
- One sub-module, io_rx_fifo: parameterised by depth and width, ready/valid push, pop strobe, full/empty/head outputs.

Test Plan:
- Reset, then load 0x80000000 -> io_rdata = 0x00000001; rx_ready = 1; tx_valid = 0.
- Store 0x41 to 0x80000008, tx_ready held 0 for 3 cycles -> tx_valid = 1 with tx_data = 0x41 from the next cycle until tx_ready pulses. A second store of 0x42 during that window stalls until the handshake, then tx_data = 0x42.
- Push 0x10, 0x11, 0x12, 0x13 on rx_valid -> STATUS = 0x7 and rx_ready = 0. Four loads of 0x80000004 return 0x10..0x13 in order, then the next load returns 0 and the FIFO stays empty.
- FIFO full, simultaneous pop and rx_valid with 0x20 -> pop returns the head. 0x20 is accepted the following cycle and occupancy returns to 4.
- With IO_COUNTERS_EN: run 100 cycles with inst_retire high for 60 of them, then store to 0x80000018 -> reads before the clear give CYCLE ≥ 100 and INSTR = 60; both read 0 the cycle after the clear. Without the macro, both offsets read 0.
- Assert rst while tx_valid = 1 and the FIFO holds 2 bytes -> tx_valid = 0, STATUS = 0x1 immediately (asynchronous) and held after release.
